// File: rtl/control_entrada_pkg.sv
// Shared key codes, entry-state encoding and keypad size for the operand-entry path.
package teclado_pkg;
    localparam int KEYPAD_N = 4;

    localparam logic [3:0] K_A   = 4'hA;
    localparam logic [3:0] K_B   = 4'hB;
    localparam logic [3:0] K_C   = 4'hC;
    localparam logic [3:0] K_D   = 4'hD;
    localparam logic [3:0] K_CLR = 4'hE;
    localparam logic [3:0] K_ENT = 4'hF;

    typedef enum logic [1:0] {
        S_OP_A = 2'b00,
        S_OP_B = 2'b01,
        S_DONE = 2'b10
    } entry_state_t;
endpackage

// File: rtl/control_entrada_if.sv
// Scanner-to-entry handshake: captured one-hot press plus valid/ack.
interface control_entrada_if #(parameter int WIDTH = 4);
    logic [WIDTH-1:0] pressed_col;
    logic [WIDTH-1:0] pressed_row;
    logic             pressed_valid;
    logic             ack_read;

    modport master (output pressed_col, pressed_row, pressed_valid, input ack_read);
    modport slave  (input pressed_col, pressed_row, pressed_valid, output ack_read);
endinterface

// File: rtl/decodificador_tecla.sv
// Combinational one-hot row/column to key code for the 4x4 keypad layout.
module decodificador_tecla
    import teclado_pkg::*;
(
    input  logic [KEYPAD_N-1:0] row,
    input  logic [KEYPAD_N-1:0] col,
    output logic [3:0]          code,
    output logic                onehot_ok
);
    logic [1:0] ri, ci;

    always_comb begin
        ri = 2'd0;
        ci = 2'd0;
        for (int i = 0; i < KEYPAD_N; i++) begin
            if (row[i]) ri = 2'(i);
            if (col[i]) ci = 2'(i);
        end
        onehot_ok = $onehot(row) && $onehot(col);
        case ({ri, ci})
            4'd0:    code = 4'h1;
            4'd1:    code = 4'h2;
            4'd2:    code = 4'h3;
            4'd3:    code = K_A;
            4'd4:    code = 4'h4;
            4'd5:    code = 4'h5;
            4'd6:    code = 4'h6;
            4'd7:    code = K_B;
            4'd8:    code = 4'h7;
            4'd9:    code = 4'h8;
            4'd10:   code = 4'h9;
            4'd11:   code = K_C;
            4'd12:   code = K_CLR;
            4'd13:   code = 4'h0;
            4'd14:   code = K_ENT;
            default: code = K_D;
        endcase
    end
endmodule

// File: rtl/control_entrada.sv
// Operand-entry controller: acks scanner presses, decodes them and builds two BCD operands.
module control_entrada
    import teclado_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int NDIG  = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    control_entrada_if.slave     kp,
    output logic [4*NDIG-1:0]    operand_a,
    output logic [4*NDIG-1:0]    operand_b,
    output logic                 operands_valid,
    output logic [1:0]           entry_state,
    output logic [3:0]           key_code,
    output logic                 key_strobe,
    output logic                 key_err
);
    localparam int CW = $clog2(NDIG + 1);

    entry_state_t     state_q, state_d;
    logic [4*NDIG-1:0] a_q, a_d, b_q, b_d;
    logic [CW-1:0]    cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
    logic [WIDTH-1:0] row_q, row_d, col_q, col_d;
    logic             ack_q, ack_d, strobe_q, strobe_d, err_q, err_d;
    logic [3:0]       code_q, code_d;

    logic [3:0]       dec_code;
    logic             dec_ok;
    logic             is_digit;
    logic [4*NDIG-1:0] digit_ext;

    decodificador_tecla u_dec (
        .row       (row_q),
        .col       (col_q),
        .code      (dec_code),
        .onehot_ok (dec_ok)
    );

    assign is_digit  = (dec_code <= 4'd9);
    assign digit_ext = {{(4*NDIG-4){1'b0}}, dec_code};

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        cnt_a_d  = cnt_a_q;
        cnt_b_d  = cnt_b_q;
        row_d    = row_q;
        col_d    = col_q;
        code_d   = code_q;
        ack_d    = 1'b0;
        strobe_d = 1'b0;
        err_d    = 1'b0;

        // ack_q marks the processing cycle; pressed_valid is ignored there
        if (ack_q) begin
            if (!dec_ok) begin
                err_d = 1'b1;
            end else begin
                strobe_d = 1'b1;
                code_d   = dec_code;
                if (dec_code == K_CLR) begin
                    state_d = S_OP_A;
                    a_d     = '0;
                    b_d     = '0;
                    cnt_a_d = '0;
                    cnt_b_d = '0;
                end else begin
                    case (state_q)
                        S_OP_A: begin
                            if (is_digit && cnt_a_q < CW'(NDIG)) begin
                                a_d     = (a_q << 4) | digit_ext;
                                cnt_a_d = cnt_a_q + CW'(1);
                            end else if (dec_code == K_A) begin
                                state_d = S_OP_B;
                                b_d     = '0;
                                cnt_b_d = '0;
                            end
                        end
                        S_OP_B: begin
                            if (is_digit && cnt_b_q < CW'(NDIG)) begin
                                b_d     = (b_q << 4) | digit_ext;
                                cnt_b_d = cnt_b_q + CW'(1);
                            end else if (dec_code == K_ENT) begin
                                state_d = S_DONE;
                            end
                        end
                        S_DONE: begin
                            if (is_digit) begin
                                state_d = S_OP_A;
                                a_d     = digit_ext;
                                b_d     = '0;
                                cnt_a_d = CW'(1);
                                cnt_b_d = '0;
                            end
                        end
                        default: state_d = S_OP_A;
                    endcase
                end
            end
        end else if (kp.pressed_valid) begin
            ack_d = 1'b1;
            row_d = kp.pressed_row;
            col_d = kp.pressed_col;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_OP_A;
            a_q      <= '0;
            b_q      <= '0;
            cnt_a_q  <= '0;
            cnt_b_q  <= '0;
            row_q    <= '0;
            col_q    <= '0;
            code_q   <= '0;
            ack_q    <= 1'b0;
            strobe_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            cnt_a_q  <= cnt_a_d;
            cnt_b_q  <= cnt_b_d;
            row_q    <= row_d;
            col_q    <= col_d;
            code_q   <= code_d;
            ack_q    <= ack_d;
            strobe_q <= strobe_d;
            err_q    <= err_d;
        end
    end

    assign kp.ack_read     = ack_q;
    assign operand_a       = a_q;
    assign operand_b       = b_q;
    assign entry_state     = state_q;
    assign operands_valid  = (state_q == S_DONE);
    assign key_code        = code_q;
    assign key_strobe      = strobe_q;
    assign key_err         = err_q;
endmodule
